// File: rtl/clkdiv_pkg.sv
// ============================================================================
// Module   : clkdiv_pkg
// Brief    : Shared FSM state encoding and constants for the divided-clock block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clkdiv_pkg;

    localparam int DEF_CNT_W = 17;
    localparam int MIN_DIV   = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/clkdiv_core.sv
// ============================================================================
// Module   : clkdiv_core
// Brief    : Period counter with registered divclk/tick; tick doubles as the boundary flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clkdiv_core #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_now,
    input  logic             run_next,
    input  logic [CNT_W-1:0] div_next,
    output logic             divclk,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // A fresh start, a wrap or leaving the running states all restart at zero.
    always_comb begin
        cnt_next = '0;
        if (run_now && run_next && !tick)
            cnt_next = cnt + 1'b1;
    end

    // Outputs are computed from the next count so they line up with cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            divclk <= 1'b0;
            tick   <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            divclk <= run_next && (cnt_next >= (div_next >> 1));
            tick   <= run_next && (cnt_next == (div_next - 1'b1));
        end
    end

endmodule

`default_nettype wire

// File: rtl/divclk_ctrl.sv
// ============================================================================
// Module   : divclk_ctrl
// Brief    : Start/stop sequencing and glitch-free divisor updates for a divided clock.
//            Optional macro DIVCLK_CTRL_PERIOD_CNT_EN adds a saturating period counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module divclk_ctrl
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             divclk,
    output logic             tick,
    output logic             active,
    output logic [CNT_W-1:0] cur_div
`ifdef DIVCLK_CTRL_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] div_next;
    logic             pend_valid;
    logic             boundary;
    logic             accept;
    logic             div_ok;
    logic             run_now;
    logic             run_next;

    assign cfg_ready = !pend_valid;
    assign accept    = cfg_valid && cfg_ready;
    assign div_ok    = (cfg_div >= CNT_W'(MIN_DIV));
    assign run_now   = (state != IDLE);
    assign run_next  = (state_next != IDLE);
    assign boundary  = tick;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (en) state_next = RUN;
            RUN:      if (!en) state_next = STOPPING;
            STOPPING: begin
                if (en)
                    state_next = RUN;
                else if (boundary)
                    state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // A divisor takes effect only while idle or exactly at a period boundary.
    always_comb begin
        div_next = cur_div;
        if (accept && div_ok && (!run_now || boundary))
            div_next = cfg_div;
        else if (pend_valid && boundary)
            div_next = pend_div;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_div    <= CNT_W'(DEFAULT_DIV);
            pend_valid <= 1'b0;
            pend_div   <= '0;
            cfg_err    <= 1'b0;
            active     <= 1'b0;
        end else begin
            state   <= state_next;
            cur_div <= div_next;
            active  <= run_next;
            cfg_err <= accept && !div_ok;
            if (pend_valid && boundary)
                pend_valid <= 1'b0;
            else if (accept && div_ok && run_now && !boundary) begin
                pend_valid <= 1'b1;
                pend_div   <= cfg_div;
            end
        end
    end

    clkdiv_core #(
        .CNT_W    (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .run_now  (run_now),
        .run_next (run_next),
        .div_next (div_next),
        .divclk   (divclk),
        .tick     (tick)
    );

`ifdef DIVCLK_CTRL_PERIOD_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            period_cnt <= '0;
        else if ((state == IDLE) && (state_next == RUN))
            period_cnt <= '0;
        else if (tick && (period_cnt != 16'hFFFF))
            period_cnt <= period_cnt + 16'd1;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_divclk_ctrl.sv
// ============================================================================
// Module   : tb_divclk_ctrl
// Brief    : Directed self-checking bench for divclk_ctrl with DEFAULT_DIV=10.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_divclk_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic [16:0] cfg_div;
    logic        cfg_ready;
    logic        cfg_err;
    logic        divclk;
    logic        tick;
    logic        active;
    logic [16:0] cur_div;
`ifdef DIVCLK_CTRL_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    int passed;
    int total;

    divclk_ctrl #(
        .CNT_W       (17),
        .DEFAULT_DIV (10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .divclk     (divclk),
        .tick       (tick),
        .active     (active),
        .cur_div    (cur_div)
`ifdef DIVCLK_CTRL_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        cyc();
        total++; if (divclk !== 1'b0) $display("FAIL reset_divclk: got %b want 0", divclk); else passed++;
        total++; if (tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", tick); else passed++;
        total++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err: got %b want 0", cfg_err); else passed++;
        total++; if (active !== 1'b0) $display("FAIL reset_active: got %b want 0", active); else passed++;
        total++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); else passed++;
        total++; if (cur_div !== 17'd10) $display("FAIL reset_cur_div: got %0d want 10", cur_div); else passed++;
        rst = 1'b0;
        cyc();
        cyc();
        total++; if (active !== 1'b0 || divclk !== 1'b0) $display("FAIL idle_hold: active/divclk got %b%b want 00", active, divclk); else passed++;
    endtask

    task automatic test_default10();
        bit ed, et;
        do_reset();
        en = 1'b1;
        cyc();
        for (int k = 0; k < 30; k++) begin
            ed = (k % 10) >= 5;
            et = (k % 10) == 9;
            total++;
            if (divclk !== ed || tick !== et || active !== 1'b1)
                $display("FAIL div10 k=%0d: divclk/tick/active got %b%b%b want %b%b1", k, divclk, tick, active, ed, et);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_odd7();
        bit ed, et;
        do_reset();
        cfg_valid = 1'b1; cfg_div = 17'd7;
        cyc();
        cfg_valid = 1'b0;
        total++; if (cur_div !== 17'd7) $display("FAIL idle_update cur_div: got %0d want 7", cur_div); else passed++;
        total++; if (cfg_ready !== 1'b1 || active !== 1'b0) $display("FAIL idle_update ready/active: got %b%b want 10", cfg_ready, active); else passed++;
        en = 1'b1;
        cyc();
        for (int k = 0; k < 21; k++) begin
            ed = (k % 7) >= 3;
            et = (k % 7) == 6;
            total++;
            if (divclk !== ed || tick !== et)
                $display("FAIL div7 k=%0d: divclk/tick got %b%b want %b%b", k, divclk, tick, ed, et);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_pending();
        int c, d;
        bit ed, et, er;
        do_reset();
        en = 1'b1;
        cyc();
        repeat (3) cyc();
        cfg_valid = 1'b1; cfg_div = 17'd4;
        cyc();
        cfg_valid = 1'b0;
        for (int k = 4; k < 22; k++) begin
            if (k <= 9) begin c = k; d = 10; er = 1'b0; end
            else begin c = (k - 10) % 4; d = 4; er = 1'b1; end
            ed = c >= (d / 2);
            et = c == (d - 1);
            total++;
            if (divclk !== ed || tick !== et || cfg_ready !== er || cur_div !== 17'(d))
                $display("FAIL pending k=%0d: divclk/tick/ready got %b%b%b cur_div %0d want %b%b%b cur_div %0d",
                         k, divclk, tick, cfg_ready, cur_div, ed, et, er, d);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_bypass();
        bit ed, et;
        do_reset();
        en = 1'b1;
        cyc();
        repeat (9) cyc();
        total++; if (tick !== 1'b1 || cfg_ready !== 1'b1) $display("FAIL bypass_edge: tick/ready got %b%b want 11", tick, cfg_ready); else passed++;
        cfg_valid = 1'b1; cfg_div = 17'd6;
        cyc();
        cfg_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            ed = (k % 6) >= 3;
            et = (k % 6) == 5;
            total++;
            if (divclk !== ed || tick !== et || cfg_ready !== 1'b1 || cur_div !== 17'd6)
                $display("FAIL bypass k=%0d: divclk/tick/ready got %b%b%b cur_div %0d want %b%b1 cur_div 6",
                         k, divclk, tick, cfg_ready, cur_div, ed, et);
            else passed++;
            cyc();
        end
    endtask

    task automatic test_err();
        logic [16:0] bads [2];
        bads[0] = 17'd1;
        bads[1] = 17'd0;
        do_reset();
        en = 1'b1;
        cyc();
        cyc();
        for (int i = 0; i < 2; i++) begin
            cfg_valid = 1'b1; cfg_div = bads[i];
            cyc();
            cfg_valid = 1'b0;
            total++; if (cfg_err !== 1'b1) $display("FAIL err_pulse D=%0d: got %b want 1", bads[i], cfg_err); else passed++;
            total++; if (cur_div !== 17'd10 || cfg_ready !== 1'b1) $display("FAIL err_nochange D=%0d: cur_div %0d ready %b want 10 1", bads[i], cur_div, cfg_ready); else passed++;
            cyc();
            total++; if (cfg_err !== 1'b0) $display("FAIL err_single D=%0d: got %b want 0", bads[i], cfg_err); else passed++;
        end
    endtask

    task automatic test_stop();
        int ticks;
        bit ed, et;
        ticks = 0;
        do_reset();
        en = 1'b1;
        cyc();
        cyc();
        cyc();
        en = 1'b0;
        cyc();
        for (int k = 3; k < 10; k++) begin
            ed = k >= 5;
            et = k == 9;
            if (tick === 1'b1) ticks++;
            total++;
            if (divclk !== ed || tick !== et || active !== 1'b1)
                $display("FAIL stop k=%0d: divclk/tick/active got %b%b%b want %b%b1", k, divclk, tick, active, ed, et);
            else passed++;
            cyc();
        end
        total++; if (active !== 1'b0 || divclk !== 1'b0 || tick !== 1'b0) $display("FAIL stop_idle: active/divclk/tick got %b%b%b want 000", active, divclk, tick); else passed++;
        repeat (12) begin
            cyc();
            if (tick === 1'b1) ticks++;
        end
        total++; if (ticks != 1) $display("FAIL stop_ticks: got %0d want 1", ticks); else passed++;
    endtask

    task automatic test_resume();
        bit ed, et;
        do_reset();
        en = 1'b1;
        cyc();
        cyc();
        cyc();
        en = 1'b0;
        cyc();
        for (int k = 3; k < 26; k++) begin
            ed = (k % 10) >= 5;
            et = (k % 10) == 9;
            total++;
            if (divclk !== ed || tick !== et || active !== 1'b1)
                $display("FAIL resume k=%0d: divclk/tick/active got %b%b%b want %b%b1", k, divclk, tick, active, ed, et);
            else passed++;
            if (k == 5) en = 1'b1;
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        cyc();
        repeat (3) cyc();
        cfg_valid = 1'b1; cfg_div = 17'd4;
        cyc();
        cfg_valid = 1'b0;
        total++; if (cfg_ready !== 1'b0) $display("FAIL mid_pending: ready got %b want 0", cfg_ready); else passed++;
        cyc();
        cyc();
        total++; if (divclk !== 1'b1 || active !== 1'b1) $display("FAIL mid_pre: divclk/active got %b%b want 11", divclk, active); else passed++;
        #3;
        rst = 1'b1;
        #1;
        total++; if (divclk !== 1'b0 || tick !== 1'b0 || active !== 1'b0 || cfg_err !== 1'b0)
            $display("FAIL mid_reset outs: divclk/tick/active/err got %b%b%b%b want 0000", divclk, tick, active, cfg_err); else passed++;
        total++; if (cfg_ready !== 1'b1 || cur_div !== 17'd10)
            $display("FAIL mid_reset cfg: ready %b cur_div %0d want 1 10", cfg_ready, cur_div); else passed++;
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) cyc();
        total++; if (active !== 1'b0 || cur_div !== 17'd10 || cfg_ready !== 1'b1)
            $display("FAIL mid_after: active %b cur_div %0d ready %b want 0 10 1", active, cur_div, cfg_ready); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        test_reset();
        test_default10();
        test_odd7();
        test_pending();
        test_bypass();
        test_err();
        test_stop();
        test_resume();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
